// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller:
// register addresses and the trap sequencing states.
package intr_pkg;

    localparam logic [11:0] INTR_ENABLE_ADDR  = 12'h7C0;
    localparam logic [11:0] INTR_PENDING_ADDR = 12'h7C1;
    localparam logic [11:0] INTR_CAUSE_ADDR   = 12'h7C2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        TRAP    = 2'd2,
        SERVICE = 2'd3
    } intr_state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Core/CSR-side bundle of the interrupt controller:
// trap handshake plus the register access bus.
interface intr_ctrl_if #(
    parameter int CAUSE_W = 3
);

    logic               csr_mie;
    logic               intr_ready;
    logic               mret;
    logic               int_taken;
    logic [CAUSE_W-1:0] cause;
    logic               w_en;
    logic [11:0]        addr;
    logic [31:0]        w_data;
    logic [31:0]        r_data;

    modport master (
        output csr_mie,
        output intr_ready,
        output mret,
        output w_en,
        output addr,
        output w_data,
        input  int_taken,
        input  cause,
        input  r_data
    );

    modport slave (
        input  csr_mie,
        input  intr_ready,
        input  mret,
        input  w_en,
        input  addr,
        input  w_data,
        output int_taken,
        output cause,
        output r_data
    );

endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the
// highest priority; valid flags any set request bit.
module intr_prio_enc #(
    parameter int N_SRC   = 8,
    parameter int CAUSE_W = 3
) (
    input  logic [N_SRC-1:0]   req,
    output logic [CAUSE_W-1:0] winner,
    output logic               valid
);

    // Scan downward so the lowest set index is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = CAUSE_W'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, enable mask,
// trap-entry sequencing. Optional macro: INTR_CTRL_SYNC_EN.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int CAUSE_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    intr_ctrl_if.slave       bus
);

    logic [N_SRC-1:0]   irq_in;
    logic [N_SRC-1:0]   irq_q;
    logic [N_SRC-1:0]   irq_edge;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   enable;
    logic [N_SRC-1:0]   masked;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   take_clr;
    logic [CAUSE_W-1:0] winner;
    logic [CAUSE_W-1:0] cause_q;
    logic               win_valid;
    logic               req;
    logic               take;
    logic               unused_wdata;
    intr_state_t        state;
    intr_state_t        state_nxt;

`ifdef INTR_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync_a;
    logic [N_SRC-1:0] sync_b;

    // Two-flop synchronizer for asynchronous request lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= irq_src;
            sync_b <= sync_a;
        end
    end

    assign irq_in = sync_b;
`else
    assign irq_in = irq_src;
`endif

    assign irq_edge     = irq_in & ~irq_q;
    assign masked       = pending & enable;
    assign req          = win_valid && bus.csr_mie;
    assign unused_wdata = ^bus.w_data;

    intr_prio_enc #(
        .N_SRC   (N_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .req    (masked),
        .winner (winner),
        .valid  (win_valid)
    );

    // Write-1-to-clear mask from the PENDING register.
    always_comb begin
        w1c = '0;
        if (bus.w_en && bus.addr == INTR_PENDING_ADDR) begin
            w1c = bus.w_data[N_SRC-1:0];
        end
    end

    // Pending bit of the source being taken.
    always_comb begin
        take_clr = '0;
        if (take) begin
            take_clr[winner] = 1'b1;
        end
    end

    // Edge history, pending (set wins) and enable mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            enable  <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~w1c & ~take_clr) | irq_edge;
            if (bus.w_en && bus.addr == INTR_ENABLE_ADDR) begin
                enable <= bus.w_data[N_SRC-1:0];
            end
        end
    end

    // Trap sequencing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; take marks the WAIT->TRAP decision.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (bus.intr_ready) begin
                    state_nxt = TRAP;
                    take      = 1'b1;
                end
            end
            TRAP: begin
                state_nxt = SERVICE;
            end
            SERVICE: begin
                if (bus.mret) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winning source when the trap is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
        end else if (take) begin
            cause_q <= winner;
        end
    end

    assign bus.int_taken = (state == TRAP);
    assign bus.cause     = cause_q;

    // Asynchronous register read mux.
    always_comb begin
        bus.r_data = '0;
        case (bus.addr)
            INTR_ENABLE_ADDR:  bus.r_data[N_SRC-1:0] = enable;
            INTR_PENDING_ADDR: bus.r_data[N_SRC-1:0] = pending;
            INTR_CAUSE_ADDR:   bus.r_data[CAUSE_W-1:0] = cause_q;
            default:           bus.r_data = '0;
        endcase
    end

endmodule
